dcmi_fifo_tx: RTL and testbench
===============================

// Module: dcmi_fifo_tx
// PURPOSE
//  Parametrised DCMI master transmitter with an internal FIFO and frame snapshot.
//  Sits behind an IOPort write strobe: the host pushes words over SPI, pulses START,
//  and the block streams one framed burst (DSYNC/DCLK/DATA) to the STM32 DCMI.
//  Adds over-fill detection, level reporting, clear/abort and configurable clock rate and gap.
// PARAMETERS
//  DW     8   data word width (DATA, DI)
//  DEPTH  16  FIFO depth in words; power of two, >=2
//  DIV    2   Clk cycles per DCLK half-period; >=1
//  GAP    2   idle DCLK periods (DSYNC low) after each frame; >=1
// PORTS
//  Clk    in   1               system clock; all logic on rising edge
//  Rst    in   1               asynchronous reset, active-high
//  DI     in   DW              write data
//  WR     in   1               write strobe, one word per Clk cycle high
//  START  in   1               frame request pulse
//  CLR    in   1               synchronous flush/abort
//  DATA   out  DW              DCMI data
//  DSYNC  out  1               frame valid, high while frame words are on DATA
//  DCLK   out  1               DCMI pixel clock; receiver samples on rising edge
//  FULL   out  1               FIFO holds DEPTH words
//  EMPTY  out  1               FIFO holds 0 words
//  LEVEL  out  $clog2(DEPTH)+1 FIFO occupancy
//  BUSY   out  1               state != IDLE
//  OVF    out  1               sticky: a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (Rst high, async): DATA=0 DSYNC=0 DCLK=0 FULL=0 EMPTY=1 LEVEL=0 BUSY=0 OVF=0;
//   FIFO emptied, state IDLE, divider cleared. All outputs are registered.
//  Write: accepted when WR=1 and FULL=0 (registered FULL, pre-edge); LEVEL/EMPTY/FULL
//   update the next cycle. WR with FULL=1 -> word dropped, OVF set. A pop in the same
//   cycle does not make room for a write blocked by FULL. Pointers wrap modulo DEPTH.
//  FSM: IDLE -> LEAD -> DATA -> TRAIL -> IDLE.
//   IDLE: DCLK held 0, DSYNC 0. START=1 and EMPTY=0 -> latch N=LEVEL (frame snapshot),
//    clear divider, go LEAD, BUSY=1 next cycle. START with EMPTY=1 or outside IDLE: ignored.
//   Divider: tick every DIV Clk cycles outside IDLE; each tick toggles DCLK
//    (one DCLK period = 2*DIV Clk). DATA/DSYNC change only on ticks taking DCLK 1->0.
//   LEAD: DSYNC=1 on entry; one DCLK period; at its falling tick pop word 1 to DATA, go DATA.
//   DATA: each falling tick pops the next word until N words presented; at the falling
//    tick after word N: DSYNC=0, DATA holds word N, go TRAIL.
//   TRAIL: GAP DCLK periods; after last falling tick -> IDLE, DCLK 0, BUSY 0.
//  Frame = exactly N words; lasts (1+N+GAP) DCLK periods. Words written during a frame
//   stay in the FIFO for the next START.
//  CLR (sync, priority over WR/START): FIFO emptied, OVF=0, FSM -> IDLE, DSYNC=0, DCLK=0,
//   DATA unchanged, divider cleared; WR in the same cycle is dropped without setting OVF.
//  Rst mid-frame: outputs to reset values immediately, no partial-word completion.
// TESTING
//  Reset: assert Rst -> all outputs at reset values; EMPTY=1, LEVEL=0, DCLK static.
//  DIV=2 GAP=2: write A1,A2,A3,A4; START -> DSYNC high, 4 DCLK rises sample A1..A4,
//   DSYNC low before 5th rise, BUSY low after 7 DCLK periods (28 Clk), LEVEL=0.
//  DEPTH=16: 17 back-to-back writes -> LEVEL=16, FULL=1, OVF=1, frame sends first 16 only.
//  Snapshot: write 3 words, START, write 2 more during frame -> 3 words sent, LEVEL=2 after.
//  START with EMPTY=1 -> BUSY stays 0, DCLK stays 0; START while BUSY -> no effect.
//  CLR during DATA state -> next cycle BUSY=0 DSYNC=0 DCLK=0 LEVEL=0 OVF=0; new frame works.

Source files
------------

// File: rtl/dcmi_fifo_tx.sv
// rtl/dcmi_fifo_tx.sv - DCMI master transmitter with internal FIFO and frame snapshot
// Streams one DSYNC-framed burst of the words present at START onto DATA/DCLK.
module dcmi_fifo_tx #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int DIV   = 2,
  parameter int GAP   = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [DW-1:0]              DI,
  input  logic                       WR,
  input  logic                       START,
  input  logic                       CLR,
  output logic [DW-1:0]              DATA,
  output logic                       DSYNC,
  output logic                       DCLK,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       BUSY,
  output logic                       OVF
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int DCW = $clog2(DIV + 1);
  localparam int GCW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_DATA, S_TRAIL} state_t;

  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q, level_d;
  logic           full_q, empty_q, ovf_q;

  state_t         state_q;
  logic [DCW-1:0] div_q;
  logic [LW-1:0]  n_q, cnt_q;
  logic [GCW-1:0] gap_q;
  logic           dclk_q, dsync_q, busy_q;
  logic [DW-1:0]  data_q;

  logic tick, fall, wr_en, pop;

  always_comb begin
    tick    = (state_q != S_IDLE) && (div_q == DCW'(DIV - 1));
    fall    = tick && dclk_q;
    wr_en   = WR && !full_q && !CLR;
    pop     = !CLR && fall &&
              ((state_q == S_LEAD) || ((state_q == S_DATA) && (cnt_q < n_q)));
    level_d = level_q + LW'(wr_en) - LW'(pop);
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr_q] <= DI;
  end

  // FULL is the registered flag, so a same-cycle pop never frees room for a blocked write
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else if (CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
      if (WR && full_q) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      dclk_q  <= 1'b0;
      dsync_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else if (CLR) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      dclk_q  <= 1'b0;
      dsync_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (START && !empty_q) begin
        n_q     <= level_q;
        cnt_q   <= '0;
        div_q   <= '0;
        dsync_q <= 1'b1;
        busy_q  <= 1'b1;
        state_q <= S_LEAD;
      end
    end else begin
      if (tick) begin
        div_q  <= '0;
        dclk_q <= !dclk_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (fall) begin
        unique case (state_q)
          S_LEAD: begin
            data_q  <= mem[rd_ptr_q];
            cnt_q   <= LW'(1);
            state_q <= S_DATA;
          end
          S_DATA: begin
            if (cnt_q < n_q) begin
              data_q <= mem[rd_ptr_q];
              cnt_q  <= cnt_q + 1'b1;
            end else begin
              dsync_q <= 1'b0;
              gap_q   <= '0;
              state_q <= S_TRAIL;
            end
          end
          S_TRAIL: begin
            if (gap_q == GCW'(GAP - 1)) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign DATA  = data_q;
  assign DSYNC = dsync_q;
  assign DCLK  = dclk_q;
  assign FULL  = full_q;
  assign EMPTY = empty_q;
  assign LEVEL = level_q;
  assign BUSY  = busy_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_dcmi_fifo_tx.sv
// tb/tb_dcmi_fifo_tx.sv - directed self-checking bench for dcmi_fifo_tx
module tb_dcmi_fifo_tx;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] DI = '0;
  logic       WR = 1'b0, START = 1'b0, CLR = 1'b0;
  logic [7:0] DATA;
  logic       DSYNC, DCLK, FULL, EMPTY, BUSY, OVF;
  logic [4:0] LEVEL;

  int passed = 0;
  int total  = 0;
  int cyc;
  logic [8:0] rises [$];

  dcmi_fifo_tx #(.DW(8), .DEPTH(16), .DIV(2), .GAP(2)) dut (
    .Clk(Clk), .Rst(Rst), .DI(DI), .WR(WR), .START(START), .CLR(CLR),
    .DATA(DATA), .DSYNC(DSYNC), .DCLK(DCLK), .FULL(FULL), .EMPTY(EMPTY),
    .LEVEL(LEVEL), .BUSY(BUSY), .OVF(OVF)
  );

  always #5 Clk = ~Clk;

  always @(posedge DCLK) if (!Rst) rises.push_back({DSYNC, DATA});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr_word(input logic [7:0] d);
    DI = d; WR = 1'b1;
    @(negedge Clk);
    WR = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge Clk);
    START = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (BUSY && c < 400) begin
      @(negedge Clk);
      c++;
    end
  endtask

  initial begin
    @(negedge Clk);
    chk("rst_data", DATA, 0);   chk("rst_dsync", DSYNC, 0); chk("rst_dclk", DCLK, 0);
    chk("rst_full", FULL, 0);   chk("rst_empty", EMPTY, 1); chk("rst_level", LEVEL, 0);
    chk("rst_busy", BUSY, 0);   chk("rst_ovf", OVF, 0);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("idle_dclk", DCLK, 0);

    // Basic 4-word frame
    wr_word(8'hA1); wr_word(8'hA2); wr_word(8'hA3); wr_word(8'hA4);
    chk("f1_level", LEVEL, 4); chk("f1_empty", EMPTY, 0);
    rises.delete();
    pulse_start();
    chk("f1_busy", BUSY, 1); chk("f1_dsync", DSYNC, 1); chk("f1_dclk0", DCLK, 0);
    wait_idle(cyc);
    chk("f1_cycles", cyc, 28);
    chk("f1_nrises", rises.size(), 7);
    chk("f1_lead", rises[0][8], 1);
    chk("f1_w1", rises[1], {1'b1, 8'hA1}); chk("f1_w2", rises[2], {1'b1, 8'hA2});
    chk("f1_w3", rises[3], {1'b1, 8'hA3}); chk("f1_w4", rises[4], {1'b1, 8'hA4});
    chk("f1_trail", rises[5][8], 0);
    chk("f1_lvl_after", LEVEL, 0); chk("f1_empty_after", EMPTY, 1); chk("f1_dclk_end", DCLK, 0);

    // Overfill: 17 writes, 16 kept
    for (int i = 0; i < 17; i++) wr_word(8'h10 + 8'(i));
    chk("ov_level", LEVEL, 16); chk("ov_full", FULL, 1); chk("ov_ovf", OVF, 1);
    rises.delete();
    pulse_start();
    wait_idle(cyc);
    chk("ov_idle", BUSY, 0);
    chk("ov_nrises", rises.size(), 19);
    chk("ov_first", rises[1], {1'b1, 8'h10});
    chk("ov_last", rises[16], {1'b1, 8'h1F});
    chk("ov_trail", rises[17][8], 0);
    chk("ov_sticky", OVF, 1); chk("ov_lvl_after", LEVEL, 0);

    // Snapshot: words written mid-frame wait for the next START
    wr_word(8'hB0); wr_word(8'hB1); wr_word(8'hB2);
    rises.delete();
    pulse_start();
    repeat (5) @(negedge Clk);
    wr_word(8'hC0); wr_word(8'hC1);
    wait_idle(cyc);
    chk("sn_idle", BUSY, 0);
    chk("sn_nrises", rises.size(), 6);
    chk("sn_w3", rises[3], {1'b1, 8'hB2});
    chk("sn_trail", rises[4][8], 0);
    chk("sn_level", LEVEL, 2);
    rises.delete();
    pulse_start();
    wait_idle(cyc);
    chk("sn2_nrises", rises.size(), 5);
    chk("sn2_w1", rises[1], {1'b1, 8'hC0}); chk("sn2_w2", rises[2], {1'b1, 8'hC1});
    chk("sn2_level", LEVEL, 0);

    // START while empty is ignored
    pulse_start();
    repeat (3) @(negedge Clk);
    chk("es_busy", BUSY, 0); chk("es_dclk", DCLK, 0);

    // START while busy is ignored
    wr_word(8'hF0); wr_word(8'hF1);
    rises.delete();
    pulse_start();
    repeat (6) @(negedge Clk);
    pulse_start();
    wait_idle(cyc);
    chk("sb_cycles", cyc, 13);
    chk("sb_nrises", rises.size(), 5);

    // CLR during DATA state; same-cycle WR dropped without OVF
    chk("cl_ovf_before", OVF, 1);
    wr_word(8'hD0); wr_word(8'hD1); wr_word(8'hD2); wr_word(8'hD3);
    pulse_start();
    repeat (10) @(negedge Clk);
    CLR = 1'b1; WR = 1'b1; DI = 8'h77;
    @(negedge Clk);
    CLR = 1'b0; WR = 1'b0;
    chk("cl_busy", BUSY, 0); chk("cl_dsync", DSYNC, 0); chk("cl_dclk", DCLK, 0);
    chk("cl_level", LEVEL, 0); chk("cl_ovf", OVF, 0); chk("cl_empty", EMPTY, 1);
    chk("cl_data", DATA, 8'hD1);
    wr_word(8'hE5);
    rises.delete();
    pulse_start();
    wait_idle(cyc);
    chk("cl2_cycles", cyc, 16);
    chk("cl2_nrises", rises.size(), 4);
    chk("cl2_w1", rises[1], {1'b1, 8'hE5});

    // Asynchronous reset mid-frame
    wr_word(8'h61); wr_word(8'h62);
    pulse_start();
    repeat (9) @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("ar_dsync", DSYNC, 0); chk("ar_dclk", DCLK, 0); chk("ar_busy", BUSY, 0);
    chk("ar_level", LEVEL, 0); chk("ar_data", DATA, 0); chk("ar_empty", EMPTY, 1);
    @(negedge Clk);
    Rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
